// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// Tenths-of-a-second stopwatch core producing MM:SS.t as packed BCD.
// All state runs on clk. The 100 ms square wave from the board divider is
// sampled as data and rising-edge detected. It is never used as a clock.
//
// Ports:
//   clk         main board clock
//   rst_n       asynchronous active-low reset
//   tick_in     100 ms square wave, synchronous to clk; rising edge = 0.1 s
//   start_stop  1-cycle pulse, toggles running
//   clear       1-cycle pulse, zeroes time, overflow and lap hold
//   lap         1-cycle pulse, toggles display freeze
//   time_bcd    live count {min_tens, min_ones, sec_tens, sec_ones, tenths}
//   disp_bcd    lap snapshot while lap_active, else the live count
//   running     1 = counting
//   lap_active  1 = disp_bcd frozen
//   overflow    sticky, set when the count wraps past MAX_MIN:59.9
//
// Every output is a flop, so there is no combinational path from an input
// to an output.
// -----------------------------------------------------------------------------

// One BCD digit of the increment chain. The digit rolls to 0 at LIMIT and
// emits a carry. A value above LIMIT also rolls to 0, so an illegal code can
// never persist.
module stopwatch_bcd_digit #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic [3:0] cur,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);
    logic at_lim;

    always_comb begin
        at_lim = (cur >= LIMIT);
        cout   = cin & at_lim;
        if (!cin)
            nxt = cur;
        else if (at_lim)
            nxt = 4'd0;
        else
            nxt = cur + 4'd1;
    end
endmodule

module stopwatch_bcd #(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [19:0] time_bcd,
    output logic [19:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);
    localparam int NUM_DIG = 5;

    // Terminal count MAX_MIN:59.9. Digit 4 is min_tens, digit 0 is tenths.
    localparam logic [19:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10),
                                       4'd5, 4'd9, 4'd9};

    logic [NUM_DIG-1:0][3:0] time_q, time_nxt, inc_val;
    logic [NUM_DIG-1:0][3:0] snap_q, snap_nxt, disp_nxt;
    logic [NUM_DIG:0]        carry;

    logic tick_prev;
    logic running_q, lap_q, ovf_q;
    logic tick_evt, do_inc, at_max;
    logic running_nxt, lap_nxt, ovf_nxt;

    // Ripple increment chain. Tenths always sees a carry-in; the result is
    // used only when a counted tick arrives.
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_DIG; i++) begin : g_dig
            localparam logic [3:0] LIM = (i == 2) ? 4'd5 : 4'd9;
            stopwatch_bcd_digit #(.LIMIT(LIM)) u_dig (
                .cur  (time_q[i]),
                .cin  (carry[i]),
                .nxt  (inc_val[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    always_comb begin
        tick_evt = tick_in & ~tick_prev;
        // running_q is the value before this cycle's start_stop, so a tick
        // that coincides with stop still counts and one with start does not.
        do_inc   = tick_evt & running_q;
        // carry out of min_tens only happens at 99:59.9, which is also the
        // terminal count when MAX_MIN = 99.
        at_max   = (time_q == MAX_BCD) | carry[NUM_DIG];

        time_nxt = time_q;
        ovf_nxt  = ovf_q;
        if (do_inc) begin
            if (at_max) begin
                time_nxt = '0;
                ovf_nxt  = 1'b1;
            end else begin
                time_nxt = inc_val;
            end
        end

        running_nxt = start_stop ? ~running_q : running_q;

        lap_nxt  = lap_q;
        snap_nxt = snap_q;
        if (clear) begin
            // clear overrides a same-cycle tick, wrap and lap pulse
            time_nxt = '0;
            ovf_nxt  = 1'b0;
            lap_nxt  = 1'b0;
            snap_nxt = '0;
        end else if (lap) begin
            if (!lap_q) begin
                // freeze the value this cycle's update produces
                snap_nxt = time_nxt;
                lap_nxt  = 1'b1;
            end else begin
                lap_nxt  = 1'b0;
            end
        end

        disp_nxt = lap_nxt ? snap_nxt : time_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // tick_prev resets high so a tick_in already high at release is
            // not taken as an edge
            tick_prev <= 1'b1;
            time_q    <= '0;
            snap_q    <= '0;
            disp_bcd  <= '0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tick_prev <= tick_in;
            time_q    <= time_nxt;
            snap_q    <= snap_nxt;
            disp_bcd  <= disp_nxt;
            running_q <= running_nxt;
            lap_q     <= lap_nxt;
            ovf_q     <= ovf_nxt;
        end
    end

    assign time_bcd   = time_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;
endmodule
